enokida_trace_fifo: RTL and testbench

Elastic buffer between the processor trace unit and the Enokida n-way trace-assisted cache. Captures 160-bit trace records when capture is enabled and holds them in a first-in-first-out store. Presents the oldest record to the cache on its `trace_in` / `trace_ready` inputs, and releases it when the cache pops it. Counts and flags records dropped on overflow.

---
 rtl/enokida_trace_fifo.sv | 132 +++++++++++++
 tb/tb_enokida_trace_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/enokida_trace_fifo.sv
// enokida_trace_fifo
// Elastic buffer between the processor trace unit and the trace-assisted
// cache. Records are captured when enabled and held first-in-first-out.
// The head record is presented combinationally and released on a pop.
// Records that arrive while the store is full are dropped and counted.
module enokida_trace_fifo #(
    parameter  int TRACE_WIDTH = 160,
    parameter  int DEPTH       = 8,
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TRACE_WIDTH-1:0] trace_data_i,
    input  logic                   trace_valid_i,
    input  logic                   trace_capture_enable,
    input  logic                   flush_i,
    input  logic                   lock,
    input  logic                   trace_pop_i,
    output logic [TRACE_WIDTH-1:0] trace_out,
    output logic                   trace_ready,
    output logic [CNT_W-1:0]       occupancy_o,
    output logic                   full_o,
    output logic                   overflow_o,
    output logic [31:0]            drop_count_o,
    output logic [CNT_W-1:0]       high_water_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Record store; contents are deliberately not reset.
    logic [TRACE_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] occ_q,    occ_d;
    logic [CNT_W-1:0] hw_q,     hw_d;
    logic             ovf_q,    ovf_d;
    logic [31:0]      drop_q,   drop_d;

    logic push_req;
    logic push_acc;
    logic pop_acc;
    logic drop;
    logic empty;
    logic full;

    assign empty    = (occ_q == '0);
    assign full     = (occ_q == CNT_W'(DEPTH));
    assign push_req = trace_valid_i && trace_capture_enable;
    // A locked head cannot be released; an empty store has nothing to pop.
    assign pop_acc  = trace_pop_i && !empty && !lock;
    // A full store still accepts a push when the head leaves in the same cycle.
    assign push_acc = push_req && (!full || pop_acc);
    // Flush discards the incoming record as well, so it is not a drop.
    assign drop     = push_req && full && !pop_acc && !flush_i;

    // Next-state for pointers, occupancy, high-water mark and drop tracking.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        hw_d     = hw_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
            hw_d     = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Push and pop together leave occupancy unchanged.
            if (push_acc && !pop_acc) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                occ_d = occ_q - CNT_W'(1);
            end
            if (occ_d > hw_q) begin
                hw_d = occ_d;
            end
        end

        // Drop statistics survive flush; only reset clears them.
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 32'hFFFF_FFFF) begin
                drop_d = drop_q + 32'd1;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            hw_q     <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            hw_q     <= hw_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Array write; an accepted push lands at the write pointer unless flushed.
    always_ff @(posedge clk) begin
        if (push_acc && !flush_i) begin
            mem_q[wr_ptr_q] <= trace_data_i;
        end
    end

    assign trace_out    = mem_q[rd_ptr_q];
    assign trace_ready  = !empty;
    assign occupancy_o  = occ_q;
    assign full_o       = full;
    assign overflow_o   = ovf_q;
    assign drop_count_o = drop_q;
    assign high_water_o = hw_q;

endmodule

// File: tb/tb_enokida_trace_fifo.sv
// Directed bench for enokida_trace_fifo: linear steps, immediate assertions.
module tb_enokida_trace_fifo;

    localparam int TW    = 160;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [TW-1:0]    trace_data_i;
    logic             trace_valid_i;
    logic             trace_capture_enable;
    logic             flush_i;
    logic             lock;
    logic             trace_pop_i;
    logic [TW-1:0]    trace_out;
    logic             trace_ready;
    logic [CNT_W-1:0] occupancy_o;
    logic             full_o;
    logic             overflow_o;
    logic [31:0]      drop_count_o;
    logic [CNT_W-1:0] high_water_o;

    int checks = 0;
    int errors = 0;
    logic [TW-1:0] q[$];
    logic [TW-1:0] nv;

    enokida_trace_fifo #(.TRACE_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .trace_data_i         (trace_data_i),
        .trace_valid_i        (trace_valid_i),
        .trace_capture_enable (trace_capture_enable),
        .flush_i              (flush_i),
        .lock                 (lock),
        .trace_pop_i          (trace_pop_i),
        .trace_out            (trace_out),
        .trace_ready          (trace_ready),
        .occupancy_o          (occupancy_o),
        .full_o               (full_o),
        .overflow_o           (overflow_o),
        .drop_count_o         (drop_count_o),
        .high_water_o         (high_water_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TW-1:0] rec(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, ~w, w ^ 32'h5A5A_5A5A, w, ~w};
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TW-1:0] d);
        trace_valid_i = 1'b1;
        trace_data_i  = d;
        tick();
        trace_valid_i = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ready"}, TW'(trace_ready), TW'(0));
        chk({tag, " occ"},   TW'(occupancy_o), TW'(0));
        chk({tag, " full"},  TW'(full_o), TW'(0));
        chk({tag, " ovf"},   TW'(overflow_o), TW'(0));
        chk({tag, " drops"}, TW'(drop_count_o), TW'(0));
        chk({tag, " hw"},    TW'(high_water_o), TW'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        trace_data_i = '0;
        trace_valid_i = 1'b0;
        trace_capture_enable = 1'b1;
        flush_i = 1'b0;
        lock = 1'b0;
        trace_pop_i = 1'b0;
        #1;
        tick();
        tick();
        chk_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // Three pushes, then drain in order.
        push(rec(1));
        chk("fallthrough ready", TW'(trace_ready), TW'(1));
        chk("fallthrough head", trace_out, rec(1));
        push(rec(2));
        push(rec(3));
        chk("abc occ", TW'(occupancy_o), TW'(3));
        chk("abc head", trace_out, rec(1));
        chk("abc hw", TW'(high_water_o), TW'(3));
        trace_pop_i = 1'b1;
        tick();
        chk("pop1 head", trace_out, rec(2));
        tick();
        chk("pop2 head", trace_out, rec(3));
        tick();
        chk("pop3 ready", TW'(trace_ready), TW'(0));
        chk("pop3 occ", TW'(occupancy_o), TW'(0));
        tick();
        chk("pop empty occ", TW'(occupancy_o), TW'(0));
        trace_pop_i = 1'b0;

        // Fill to full, then overflow by one.
        for (int i = 0; i < DEPTH; i++) begin
            push(rec(10 + i));
            q.push_back(rec(10 + i));
        end
        chk("fill full", TW'(full_o), TW'(1));
        chk("fill drops", TW'(drop_count_o), TW'(0));
        push(rec(18));
        chk("ovf full", TW'(full_o), TW'(1));
        chk("ovf drops", TW'(drop_count_o), TW'(1));
        chk("ovf flag", TW'(overflow_o), TW'(1));
        chk("ovf head", trace_out, rec(10));
        chk("ovf hw", TW'(high_water_o), TW'(8));
        chk("ovf occ", TW'(occupancy_o), TW'(8));

        // Push and pop together while full, across pointer wrap.
        trace_pop_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("stream head %0d", k), trace_out, q[0]);
            nv = rec(20 + k);
            trace_valid_i = 1'b1;
            trace_data_i  = nv;
            tick();
            void'(q.pop_front());
            q.push_back(nv);
        end
        trace_valid_i = 1'b0;
        chk("stream occ", TW'(occupancy_o), TW'(8));
        chk("stream drops", TW'(drop_count_o), TW'(1));
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("drain head %0d", k), trace_out, q.pop_front());
            tick();
        end
        chk("drain ready", TW'(trace_ready), TW'(0));
        trace_pop_i = 1'b0;

        // Lock freezes the head even with pops requested.
        push(rec(40));
        push(rec(41));
        lock = 1'b1;
        trace_pop_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("lock head", trace_out, rec(40));
        chk("lock occ", TW'(occupancy_o), TW'(2));
        lock = 1'b0;
        tick();
        chk("unlock head", trace_out, rec(41));
        chk("unlock occ", TW'(occupancy_o), TW'(1));
        tick();
        trace_pop_i = 1'b0;
        chk("unlock empty", TW'(trace_ready), TW'(0));

        // Capture disabled: valid records ignored, not counted as drops.
        trace_capture_enable = 1'b0;
        trace_valid_i = 1'b1;
        trace_data_i = rec(50);
        for (int k = 0; k < 10; k++) tick();
        chk("nocap occ", TW'(occupancy_o), TW'(0));
        chk("nocap drops", TW'(drop_count_o), TW'(1));
        trace_valid_i = 1'b0;
        trace_capture_enable = 1'b1;

        // Push with pop while empty: pop ignored, record stored.
        trace_pop_i = 1'b1;
        push(rec(60));
        chk("emptypp occ", TW'(occupancy_o), TW'(1));
        chk("emptypp head", trace_out, rec(60));
        tick();
        trace_pop_i = 1'b0;
        chk("emptypp drain", TW'(occupancy_o), TW'(0));

        // Flush wins over a simultaneous push and pop.
        for (int i = 0; i < 5; i++) push(rec(70 + i));
        chk("preflush occ", TW'(occupancy_o), TW'(5));
        flush_i = 1'b1;
        trace_pop_i = 1'b1;
        push(rec(80));
        flush_i = 1'b0;
        trace_pop_i = 1'b0;
        chk("flush occ", TW'(occupancy_o), TW'(0));
        chk("flush ready", TW'(trace_ready), TW'(0));
        chk("flush hw", TW'(high_water_o), TW'(0));
        chk("flush drops", TW'(drop_count_o), TW'(1));
        chk("flush ovf", TW'(overflow_o), TW'(1));
        push(rec(90));
        chk("postflush head", trace_out, rec(90));
        chk("postflush hw", TW'(high_water_o), TW'(1));

        // Reset asserted asynchronously mid-burst.
        trace_valid_i = 1'b1;
        trace_data_i = rec(91);
        tick();
        trace_data_i = rec(92);
        tick();
        chk("burst occ", TW'(occupancy_o), TW'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async rst");
        tick();
        chk_reset_state("held rst");
        trace_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("after rst occ", TW'(occupancy_o), TW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
